wfg_core_seq: RTL and testbench
===============================

Name: wfg_core_seq

Overview:
- Sequencer that reconfigures wfg_core over time from a small table of pattern entries. Each entry holds sync count, subcycle count and repeat count.
- Drives the core's enable and configuration inputs, counts the core's wfg_pat_sync pulses, and steps through entries only at sync-period boundaries.
- Sits between the register block and wfg_core, in place of the direct register-to-core connection.

Parameters:
- DEPTH, 8, number of table entries; power of two, 2..16. Localparam AW = $clog2(DEPTH).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  single-cycle pulse: begin sequence at entry 0.
- stop_i  in  1  single-cycle pulse: graceful stop at the end of the current sync period.
- loop_i  in  1  1 = wrap to entry 0 after the last entry; sampled at the last-entry boundary.
- num_entries_i  in  AW+1  number of valid entries; values above DEPTH are treated as DEPTH.
- tbl_we_i  in  1  table write strobe.
- tbl_addr_i  in  AW  table write index.
- tbl_wdata_i  in  32  table entry: [7:0] sync, [23:8] subcycle, [31:24] repeat.
- wfg_pat_sync_i  in  1  sync pulse from wfg_core.
- core_en_o  out  1  to wfg_core en_i.
- core_sync_count_o  out  8  to wfg_core wfg_sync_count_i.
- core_subcycle_count_o  out  16  to wfg_core wfg_subcycle_count_i.
- busy_o  out  1  sequencer not IDLE.
- entry_idx_o  out  AW  index of the entry currently applied.
- done_o  out  1  single-cycle pulse on sequence completion.

Behaviour:
- Reset values: all outputs 0; all table entries 0; state IDLE; rep_cnt 0; stop_pend 0.
- Table writes: accepted in any state, 1-cycle write. A written entry takes effect at the next LOAD of that index, never mid-period.
- States: IDLE, LOAD, RUN, STOP.
- IDLE:
  - core_en_o = 0.
  - start_i && eff_num != 0 && !stop_i -> LOAD with idx = 0.
  - start_i with eff_num == 0, or start_i together with stop_i, is ignored.
- LOAD (exactly 1 cycle):
  - Registers entry[idx] into core_sync_count_o / core_subcycle_count_o; rep_cnt = 0 -> RUN.
  - core_en_o is 1 in the same cycle as the config update, so enable never toggles between entries.
  - From IDLE, core_en_o rises together with the config; the first RUN cycle already sees valid config.
- RUN:
  - core_en_o = 1; counts wfg_pat_sync_i pulses.
  - Repeat field R means R+1 sync periods per entry (R = 0 gives 1 period, R = 255 gives 256).
  - On a sync pulse with rep_cnt != R: rep_cnt++.
  - On a sync pulse with rep_cnt == R: if stop_pend -> STOP; else if idx != eff_num-1 -> idx++, LOAD; else if loop_i -> idx = 0, LOAD; else -> STOP.
- stop_i:
  - In LOAD or RUN, sets stop_pend; the next sync pulse -> STOP regardless of rep_cnt.
  - stop_i arriving in the same cycle as a sync pulse counts for that pulse.
  - Ignored in IDLE and STOP.
- STOP (1 cycle): core_en_o = 0, done_o = 1, stop_pend cleared -> IDLE. Config outputs hold their last values.
- start_i while busy is ignored.
- entry_idx_o = idx at all times; busy_o = (state != IDLE).
- num_entries_i is sampled at every boundary decision. If it shrinks below idx+1 while running, the current entry is treated as the last one.
- rep_cnt is 8-bit and never wraps, because it is compared before increment.
- Reset asserted mid-sequence: immediate return to reset values, including table contents and core_en_o = 0.
- Latency: start_i -> core_en_o high = 2 cycles (IDLE->LOAD edge, then LOAD registers). Boundary sync pulse -> new config = 2 cycles.

Decomposition:
- Package wfg_core_seq_pkg holds:
  - the state enum typedef (IDLE, LOAD, RUN, STOP);
  - the packed struct wfg_seq_entry_t {repeat[7:0], subcycle[15:0], sync[7:0]};
  - field-position localparams.
- Sub-module wfg_core_seq_tbl: DEPTH x 32 flop register file with async-reset, one write port and one combinational read port. The FSM, counters and output registers stay in wfg_core_seq.

Test Plan:
- Basic run:
  - Stimulus: entries 0 = {sync 4, sub 10, rep 0} and 1 = {sync 2, sub 5, rep 2}; num = 2, loop = 0; start.
  - Required: config 4/10 for 1 sync, then 2/5 for 3 syncs; core_en_o falls and done_o pulses 1 cycle after the 4th sync; entry_idx_o sequence 0, 1.
- Loop:
  - Stimulus: same table, loop = 1; run 10 syncs, then clear loop_i.
  - Required: idx pattern 0,1,1,1,0,1,1,1,0,...; sequence ends at the next last-entry boundary; core_en_o never drops between entries.
- Graceful stop:
  - Stimulus: entry 0 rep = 255; stop_i at the 3rd RUN cycle.
  - Required: STOP on the very next sync, not after 256; done_o = 1; stop_i coincident with a sync pulse also stops on that pulse.
- Edge starts:
  - Stimulus: num_entries = 0 with start -> ignored, busy_o stays 0; start+stop together -> ignored; start while busy -> no restart (idx unchanged).
  - Stimulus: num_entries = 15 with DEPTH = 8.
  - Required: idx wraps/ends at 7.
- Live table write:
  - Stimulus: rewrite entry 1 while entry 1 is running.
  - Required: outputs unchanged until the next LOAD of index 1, then show the new values.
- Async reset:
  - Stimulus: assert rst_n = 0 mid-RUN between clock edges.
  - Required: core_en_o = 0, busy_o = 0 and all outputs 0 immediately (no clock); table reads 0 after release.

Source files
------------

// File: rtl/wfg_core_seq_pkg.sv
// rtl/wfg_core_seq_pkg.sv - shared types and field positions for the wfg_core sequencer
//
// Contents:
//   seq_state_t      sequencer FSM states
//   wfg_seq_entry_t  one table entry {rpt, subcycle, sync}
//   *_LSB / *_W      bit positions of the fields inside a 32-bit table write word
package wfg_core_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } seq_state_t;

    // rpt = R means the entry is held for R+1 sync periods
    typedef struct packed {
        logic [7:0]  rpt;
        logic [15:0] subcycle;
        logic [7:0]  sync;
    } wfg_seq_entry_t;

    localparam int SYNC_LSB = 0;
    localparam int SYNC_W   = 8;
    localparam int SUB_LSB  = 8;
    localparam int SUB_W    = 16;
    localparam int REP_LSB  = 24;
    localparam int REP_W    = 8;

endpackage

// File: rtl/wfg_core_seq_tbl.sv
// rtl/wfg_core_seq_tbl.sv - DEPTH-entry flop register file holding sequencer pattern entries
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears every entry)
//   we          write strobe
//   waddr       write index
//   wdata       32-bit entry word, split into fields on write
//   raddr       read index
//   rdata       combinational read of entry[raddr]
module wfg_core_seq_tbl
    import wfg_core_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [31:0]    wdata,
    input  logic [AW-1:0]  raddr,
    output wfg_seq_entry_t rdata
);

    wfg_seq_entry_t mem [DEPTH];
    wfg_seq_entry_t wentry;

    always_comb begin
        wentry          = '0;
        wentry.sync     = wdata[SYNC_LSB +: SYNC_W];
        wentry.subcycle = wdata[SUB_LSB +: SUB_W];
        wentry.rpt      = wdata[REP_LSB +: REP_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wentry;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/wfg_core_seq.sv
// rtl/wfg_core_seq.sv - table-driven sequencer that reconfigures wfg_core at sync-period boundaries
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start_i / stop_i        start at entry 0 / graceful stop at end of current sync period
//   loop_i                  wrap to entry 0 after the last entry
//   num_entries_i           number of valid entries (clamped to DEPTH)
//   tbl_we_i/addr_i/wdata_i table write port
//   wfg_pat_sync_i          sync pulse from wfg_core
//   core_en_o, core_sync_count_o, core_subcycle_count_o  wfg_core enable and configuration
//   busy_o, entry_idx_o, done_o                          status
module wfg_core_seq
    import wfg_core_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          loop_i,
    input  logic [AW:0]   num_entries_i,
    input  logic          tbl_we_i,
    input  logic [AW-1:0] tbl_addr_i,
    input  logic [31:0]   tbl_wdata_i,
    input  logic          wfg_pat_sync_i,
    output logic          core_en_o,
    output logic [7:0]    core_sync_count_o,
    output logic [15:0]   core_subcycle_count_o,
    output logic          busy_o,
    output logic [AW-1:0] entry_idx_o,
    output logic          done_o
);

    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

    seq_state_t     state, nxt_state;
    logic [AW-1:0]  idx;
    logic [7:0]     rep_cnt;
    logic [7:0]     cur_rep;
    logic           stop_pend;
    wfg_seq_entry_t rd_entry;

    logic [AW:0]    eff_num;
    logic           is_last;
    logic           idx_zero;
    logic           idx_inc;
    logic           en_d;

    wfg_core_seq_tbl #(.DEPTH(DEPTH)) u_tbl (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (tbl_we_i),
        .waddr (tbl_addr_i),
        .wdata (tbl_wdata_i),
        .raddr (idx),
        .rdata (rd_entry)
    );

    assign eff_num = (num_entries_i > DEPTH_N) ? DEPTH_N : num_entries_i;
    // ">=" rather than "==" so a table shrunk below idx+1 mid-run ends at the current entry
    assign is_last = (({1'b0, idx} + (AW+1)'(1)) >= eff_num);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Next-state logic and index-update decisions
    always_comb begin
        nxt_state = state;
        idx_zero  = 1'b0;
        idx_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i && !stop_i && (eff_num != '0)) begin
                    nxt_state = ST_LOAD;
                    idx_zero  = 1'b1;
                end
            end
            ST_LOAD: nxt_state = ST_RUN;
            ST_RUN: begin
                if (wfg_pat_sync_i) begin
                    // a stop_i coincident with the sync pulse counts for this pulse
                    if (stop_pend || stop_i) begin
                        nxt_state = ST_STOP;
                    end else if (rep_cnt == cur_rep) begin
                        if (!is_last) begin
                            nxt_state = ST_LOAD;
                            idx_inc   = 1'b1;
                        end else if (loop_i) begin
                            nxt_state = ST_LOAD;
                            idx_zero  = 1'b1;
                        end else begin
                            nxt_state = ST_STOP;
                        end
                    end
                end
            end
            ST_STOP: nxt_state = ST_IDLE;
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Output decode. Enable is registered so it rises on the same edge that loads the
    // first config, and stays high across LOAD between entries.
    always_comb begin
        en_d   = 1'b0;
        done_o = 1'b0;
        busy_o = (state != ST_IDLE);
        case (state)
            ST_LOAD: en_d = 1'b1;
            ST_RUN:  en_d = (nxt_state != ST_STOP);
            ST_STOP: done_o = 1'b1;
            default: en_d = 1'b0;
        endcase
    end

    // Datapath: index, repeat counter, stop request, core configuration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx                   <= '0;
            rep_cnt               <= '0;
            cur_rep               <= '0;
            stop_pend             <= 1'b0;
            core_en_o             <= 1'b0;
            core_sync_count_o     <= '0;
            core_subcycle_count_o <= '0;
        end else begin
            core_en_o <= en_d;

            if (idx_zero) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + AW'(1);
            end

            if ((state == ST_LOAD) || (state == ST_RUN)) begin
                if (stop_i) begin
                    stop_pend <= 1'b1;
                end
            end else begin
                stop_pend <= 1'b0;
            end

            if (state == ST_LOAD) begin
                core_sync_count_o     <= rd_entry.sync;
                core_subcycle_count_o <= rd_entry.subcycle;
                cur_rep               <= rd_entry.rpt;
                rep_cnt               <= '0;
            end else if ((state == ST_RUN) && wfg_pat_sync_i && (rep_cnt != cur_rep)) begin
                // compared before increment, so rep_cnt never exceeds cur_rep and never wraps
                rep_cnt <= rep_cnt + 8'd1;
            end
        end
    end

    assign entry_idx_o = idx;

endmodule

// File: tb/tb_wfg_core_seq.sv
// tb/tb_wfg_core_seq.sv - self-checking bench for wfg_core_seq with a period-level reference model
module tb_wfg_core_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i, stop_i, loop_i;
    logic [3:0]  num_entries_i;
    logic        tbl_we_i;
    logic [2:0]  tbl_addr_i;
    logic [31:0] tbl_wdata_i;
    logic        wfg_pat_sync_i;
    logic        core_en_o;
    logic [7:0]  core_sync_count_o;
    logic [15:0] core_subcycle_count_o;
    logic        busy_o;
    logic [2:0]  entry_idx_o;
    logic        done_o;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: table contents and the config latched at the last modelled LOAD
    logic [31:0] m_tbl [8];
    int          m_idx, m_cnt, m_rep, m_sync, m_sub;

    wfg_core_seq #(.DEPTH(8)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start_i               (start_i),
        .stop_i                (stop_i),
        .loop_i                (loop_i),
        .num_entries_i         (num_entries_i),
        .tbl_we_i              (tbl_we_i),
        .tbl_addr_i            (tbl_addr_i),
        .tbl_wdata_i           (tbl_wdata_i),
        .wfg_pat_sync_i        (wfg_pat_sync_i),
        .core_en_o             (core_en_o),
        .core_sync_count_o     (core_sync_count_o),
        .core_subcycle_count_o (core_subcycle_count_o),
        .busy_o                (busy_o),
        .entry_idx_o           (entry_idx_o),
        .done_o                (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ent(input int sync, input int sub, input int rep);
        return {rep[7:0], sub[15:0], sync[7:0]};
    endfunction

    task automatic twr(input int a, input logic [31:0] d);
        tbl_we_i    = 1'b1;
        tbl_addr_i  = a[2:0];
        tbl_wdata_i = d;
        tick();
        tbl_we_i    = 1'b0;
        m_tbl[a]    = d;
    endtask

    task automatic model_load();
        m_cnt  = 0;
        m_sync = int'(m_tbl[m_idx][7:0]);
        m_sub  = int'(m_tbl[m_idx][23:8]);
        m_rep  = int'(m_tbl[m_idx][31:24]);
    endtask

    task automatic start_seq();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("load_busy", 32'(busy_o), 32'd1);
        chk("load_en_low", 32'(core_en_o), 32'd0);
        tick();
        m_idx = 0;
        model_load();
    endtask

    function automatic int eff_num();
        return (int'(num_entries_i) > 8) ? 8 : int'(num_entries_i);
    endfunction

    // Drives sync pulses from the first RUN cycle to completion, checking each period's config.
    task automatic run_seq(input int clear_loop_at, input int wr_at, input int wr_idx,
                           input logic [31:0] wr_d);
        int periods = 0;
        bit fin = 1'b0;
        while (!fin) begin
            chk("run_en", 32'(core_en_o), 32'd1);
            chk("run_idx", 32'(entry_idx_o), 32'(m_idx));
            chk("run_sync", 32'(core_sync_count_o), 32'(m_sync));
            chk("run_sub", 32'(core_subcycle_count_o), 32'(m_sub));
            if (periods == wr_at) begin
                twr(wr_idx, wr_d);
                chk("live_wr_sync_held", 32'(core_sync_count_o), 32'(m_sync));
                chk("live_wr_sub_held", 32'(core_subcycle_count_o), 32'(m_sub));
            end
            repeat ($urandom_range(0, 2)) tick();
            if (periods == clear_loop_at) loop_i = 1'b0;
            wfg_pat_sync_i = 1'b1;
            tick();
            wfg_pat_sync_i = 1'b0;
            periods++;
            if (m_cnt != m_rep) begin
                m_cnt++;
            end else if ((m_idx + 1 < eff_num()) || loop_i) begin
                m_idx = (m_idx + 1 < eff_num()) ? m_idx + 1 : 0;
                chk("boundary_en_held", 32'(core_en_o), 32'd1);
                tick();
                model_load();
            end else begin
                fin = 1'b1;
            end
            if (periods > 400) begin
                n_checks++;
                $error("FAIL period_budget observed=%0d expected<=400", periods);
                fin = 1'b1;
            end
        end
        chk("end_en", 32'(core_en_o), 32'd0);
        chk("end_done", 32'(done_o), 32'd1);
        chk("end_idx", 32'(entry_idx_o), 32'(m_idx));
        tick();
        chk("idle_done", 32'(done_o), 32'd0);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_sync_hold", 32'(core_sync_count_o), 32'(m_sync));
    endtask

    initial begin
        rst_n = 1'b0;
        start_i = 1'b0; stop_i = 1'b0; loop_i = 1'b0;
        num_entries_i = '0; tbl_we_i = 1'b0; tbl_addr_i = '0; tbl_wdata_i = '0;
        wfg_pat_sync_i = 1'b0;
        for (int i = 0; i < 8; i++) m_tbl[i] = '0;
        tick();
        tick();
        chk("rst_en", 32'(core_en_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_idx", 32'(entry_idx_o), 32'd0);
        chk("rst_sync", 32'(core_sync_count_o), 32'd0);
        chk("rst_sub", 32'(core_subcycle_count_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // basic run
        twr(0, ent(4, 10, 0));
        twr(1, ent(2, 5, 2));
        num_entries_i = 4'd2;
        loop_i = 1'b0;
        start_seq();
        run_seq(-1, -1, 0, '0);

        // loop for 10 syncs then clear loop
        loop_i = 1'b1;
        start_seq();
        run_seq(10, -1, 0, '0);

        // live write of entry 1 while entry 1 runs
        twr(0, ent(1, 1, 0));
        twr(1, ent(2, 2, 1));
        loop_i = 1'b1;
        start_seq();
        run_seq(4, 1, 1, ent(9, 99, 0));

        // randomized tables, including num_entries above DEPTH
        for (int it = 0; it < 6; it++) begin
            for (int e = 0; e < 8; e++) begin
                twr(e, ent($urandom_range(0, 255), $urandom_range(0, 65535), $urandom_range(0, 2)));
            end
            num_entries_i = (it == 0) ? 4'd15 : 4'($urandom_range(1, 8));
            loop_i = 1'($urandom_range(0, 1));
            start_seq();
            run_seq(loop_i ? int'($urandom_range(3, 14)) : -1, -1, 0, '0);
        end

        // graceful stop with rep = 255
        twr(0, ent(7, 70, 255));
        num_entries_i = 4'd1;
        loop_i = 1'b0;
        start_seq();
        chk("gs_sync", 32'(core_sync_count_o), 32'd7);
        tick();
        tick();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        tick();
        chk("gs_pend_en", 32'(core_en_o), 32'd1);
        wfg_pat_sync_i = 1'b1;
        tick();
        wfg_pat_sync_i = 1'b0;
        chk("gs_stop_en", 32'(core_en_o), 32'd0);
        chk("gs_stop_done", 32'(done_o), 32'd1);
        tick();
        chk("gs_idle_busy", 32'(busy_o), 32'd0);

        // stop coincident with a sync pulse
        start_seq();
        wfg_pat_sync_i = 1'b1;
        tick();
        wfg_pat_sync_i = 1'b0;
        chk("gs2_no_stop", 32'(core_en_o), 32'd1);
        tick();
        stop_i = 1'b1;
        wfg_pat_sync_i = 1'b1;
        tick();
        stop_i = 1'b0;
        wfg_pat_sync_i = 1'b0;
        chk("gs2_done", 32'(done_o), 32'd1);
        chk("gs2_en", 32'(core_en_o), 32'd0);
        tick();

        // start with zero entries is ignored
        num_entries_i = 4'd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("num0_busy", 32'(busy_o), 32'd0);
        tick();
        chk("num0_en", 32'(core_en_o), 32'd0);

        // start together with stop is ignored
        num_entries_i = 4'd2;
        start_i = 1'b1;
        stop_i = 1'b1;
        tick();
        start_i = 1'b0;
        stop_i = 1'b0;
        chk("startstop_busy", 32'(busy_o), 32'd0);

        // start while busy does not restart
        twr(0, ent(4, 10, 0));
        twr(1, ent(2, 5, 2));
        start_seq();
        wfg_pat_sync_i = 1'b1;
        tick();
        wfg_pat_sync_i = 1'b0;
        tick();
        chk("busy_idx1", 32'(entry_idx_o), 32'd1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("restart_idx", 32'(entry_idx_o), 32'd1);
        tick();
        chk("restart_sync", 32'(core_sync_count_o), 32'd2);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        wfg_pat_sync_i = 1'b1;
        tick();
        wfg_pat_sync_i = 1'b0;
        chk("restart_stop_done", 32'(done_o), 32'd1);
        tick();

        // asynchronous reset mid-RUN
        num_entries_i = 4'd1;
        start_seq();
        tick();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_en", 32'(core_en_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_sync", 32'(core_sync_count_o), 32'd0);
        chk("arst_sub", 32'(core_subcycle_count_o), 32'd0);
        chk("arst_idx", 32'(entry_idx_o), 32'd0);
        chk("arst_done", 32'(done_o), 32'd0);
        for (int i = 0; i < 8; i++) m_tbl[i] = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        start_seq();
        chk("arst_tbl_sync", 32'(core_sync_count_o), 32'd0);
        chk("arst_tbl_sub", 32'(core_subcycle_count_o), 32'd0);
        run_seq(-1, -1, 0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
